// File: rtl/power_seq_pkg.sv
// Shared constants for the multi-channel power sequencer: FSM state encoding,
// default step interval and step counter width.
package power_seq_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned ST_W   = 3;

    localparam logic [CNT_W-1:0] STEP_DLY_DEF = 8'd50;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_UP    = 3'd1;
    localparam logic [ST_W-1:0] S_ON    = 3'd2;
    localparam logic [ST_W-1:0] S_DOWN  = 3'd3;
    localparam logic [ST_W-1:0] S_FAULT = 3'd4;

endpackage

// File: rtl/seq_step_timer.sv
// Step interval timer: counts while enabled, wraps to zero at STEP_DLY-1 and
// flags that terminal count combinationally.
module seq_step_timer
    import power_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] STEP_DLY = STEP_DLY_DEF
) (
    input  logic i_clk_50,
    input  logic i_rst_n,
    input  logic clr,
    input  logic en,
    output logic done_c
);

    localparam logic [CNT_W-1:0] LAST = STEP_DLY - CNT_W'(1);

    logic [CNT_W-1:0] count;

    assign done_c = (count == LAST);

    always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= done_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/power_sequencer.sv
// Multi-channel power sequencer: channels come up one per step interval from
// bit 0, go down in reverse order on stop, and a fault drops everything at once.
module power_sequencer
    import power_seq_pkg::*;
#(
    parameter int unsigned      N_CH     = 4,
    parameter logic [CNT_W-1:0] STEP_DLY = STEP_DLY_DEF
) (
    input  logic              i_clk_50,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_fault,
    input  logic              i_fault_clr,
    output logic [N_CH-1:0]   o_ch_en,
    output logic [STEP_W-1:0] o_step,
    output logic              o_busy,
    output logic              o_on,
    output logic              o_fault
);

    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(N_CH - 1);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_n;
    logic [N_CH-1:0]   ch_en_n;
    logic [STEP_W-1:0] step_n;
    logic              start_q;
    logic              start_edge;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_done;

    assign start_edge = i_start & ~start_q;

    seq_step_timer #(
        .STEP_DLY (STEP_DLY)
    ) u_timer (
        .i_clk_50 (i_clk_50),
        .i_rst_n  (i_rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .done_c   (tmr_done)
    );

    // State, enable run and decoded status flags all move on the same edge
    always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            o_ch_en <= '0;
            o_step  <= '0;
            o_busy  <= 1'b0;
            o_on    <= 1'b0;
            o_fault <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            o_ch_en <= ch_en_n;
            o_step  <= step_n;
            o_busy  <= (state_n == S_UP) || (state_n == S_DOWN);
            o_on    <= (state_n == S_ON);
            o_fault <= (state_n == S_FAULT);
            start_q <= i_start;
        end
    end

    // Next state; fault beats stop beats start. Enables stay a run from bit 0,
    // so stepping up is shift-in-one and stepping down is shift-right.
    always_comb begin
        state_n = state;
        ch_en_n = o_ch_en;
        step_n  = o_step;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        if (i_fault) begin
            state_n = S_FAULT;
            ch_en_n = '0;
            step_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge && !i_stop) begin
                        state_n = S_UP;
                    end
                end
                S_UP: begin
                    if (i_stop) begin
                        state_n = S_DOWN;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_en  = 1'b1;
                        if (tmr_done) begin
                            ch_en_n = (o_ch_en << 1) | N_CH'(1);
                            step_n  = o_step + STEP_W'(1);
                            if (o_step == LAST_IDX) begin
                                state_n = S_ON;
                            end
                        end
                    end
                end
                S_ON: begin
                    if (i_stop) begin
                        state_n = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (o_step == STEP_W'(0)) begin
                        state_n = S_IDLE;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_en  = 1'b1;
                        if (tmr_done) begin
                            ch_en_n = o_ch_en >> 1;
                            step_n  = o_step - STEP_W'(1);
                            if (o_step == STEP_W'(1)) begin
                                state_n = S_IDLE;
                            end
                        end
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    ch_en_n = '0;
                    step_n  = '0;
                end
            endcase
        end
    end

endmodule
